dlsc_pcie_s6_cpl_gen: RTL
=========================

// Module: dlsc_pcie_s6_cpl_gen
// PURPOSE
//  Completion TLP generator for the inbound (PCIe->local) path. Turns completion requests plus a
//  read-data stream into 3DW Cpl/CplD TLPs on a 32-bit valid/ready stream that feeds the TX
//  mux's ib_tx_* port. Flags unsuccessful completions with tx_error so the mux can route them
//  to the core's error-reporting interface.
// PARAMETERS
//  MAX_PAYLOAD  32  max CplD payload in DW; power of 2, 1..32; used only with split feature
// PORTS
//  clk          in   1   clock (one clock domain)
//  rst_n        in   1   reset, asynchronous, active-low
//  cpl_id       in   16  completer ID {bus,dev,func}, quasi-static
//  req_ready    out  1   request accepted when req_ready && req_valid
//  req_valid    in   1   request valid
//  req_status   in   3   completion status (000=SC, 001=UR, 100=CA)
//  req_reqid    in   16  requester ID
//  req_tag      in   8   tag
//  req_tc       in   3   traffic class
//  req_attr     in   2   attributes
//  req_addr     in   7   lower address of first byte
//  req_bytes    in   12  remaining byte count (0=4096)
//  req_len      in   10  payload length in DW (0=1024); ignored if status!=SC
//  dat_ready    out  1   read-data handshake
//  dat_valid    in   1   read data valid
//  dat_data     in   32  read data, one DW per beat
//  tx_ready     in   1   to mux ib_tx_ready
//  tx_valid     out  1   to mux ib_tx_valid
//  tx_last      out  1   last DW of TLP
//  tx_error     out  1   TLP is an unsuccessful completion; constant across the TLP
//  tx_data      out  32  TLP DW
// BEHAVIOUR
//  - Reset: req_ready=0, dat_ready=0, tx_valid=0, tx_last=0, tx_error=0, tx_data=0; state IDLE.
//    Reset mid-TLP aborts it; no partial TLP resumes after reset.
//  - Output register: tx_* loaded when (tx_ready || !tx_valid) and a DW is available;
//    tx_valid holds with tx_* stable until tx_ready.
//  - FSM: IDLE -> H0 -> H1 -> H2 -> DATA -> IDLE; Cpl without data: H2 -> IDLE.
//    req_ready=1 only in IDLE; accepted fields registered; H0 presented on tx the following cycle.
//    Each state advances when its DW is loaded into the output register.
//  - H0: fmt=10/type=01010 (CplD) if status==SC else fmt=00 (Cpl); [22:20]=tc, [13:12]=attr,
//    TD=EP=0, [9:0]=chunk length (0 for Cpl).
//  - H1: {cpl_id, status, BCM=0, byte_count[11:0]}. H2: {reqid, tag, 1'b0, lower_addr[6:0]}.
//  - tx_last is set on H2 for Cpl, and on the final DATA DW for CplD.
//  - DATA: dat_ready = st==DATA && (tx_ready || !tx_valid); data passes through with 1-cycle
//    latency and no bubbles while both sides are ready. An upstream stall (dat_valid=0)
//    deasserts tx_valid; the TLP resumes when data returns.
//  - status!=SC: tx_error=1 on all 3 DW; dat stream is not consumed.
//  - Back-to-back: IDLE is entered for at least one cycle between requests (1-cycle gap).
// CONFIGURATION
//  - DLSC_PCIE_CPL_SPLIT_EN defined:
//    - CplD is split into chunks of at most MAX_PAYLOAD DW.
//    - First chunk is shortened so later chunks start on a MAX_PAYLOAD*4 byte boundary:
//      len0 = min(len, MAX_PAYLOAD - addr[6:2] mod MAX_PAYLOAD).
//    - Per chunk: byte_count = remaining bytes; lower_addr = 7-bit running address (wraps).
//      First chunk consumes len0*4 - addr[1:0] bytes; later chunks consume chunk*4 bytes.
//    - Chunk headers are re-emitted without returning to IDLE; tx_last ends every chunk.
//  - Not defined: one CplD of req_len DW; MAX_PAYLOAD unused.
// STRUCTURE
//  - Shared package dlsc_pcie_tlp_params.vh holds: CPL_SC/CPL_UR/CPL_CA codes, FMT_*/TYPE_CPL
//    constants, header bit-field positions. Shared with dlsc_pcie_s6_tx.
//  - Single module with no sub-modules. Length/byte-count/address bookkeeping lives in one
//    always block.
// TESTING
//  1. SC, len=1, addr=0x04, bytes=4, tag=0x12, one data DW 0xDEADBEEF, tx_ready=1
//     -> 4 DW: H0=0x4A000001, H1={cpl_id,0x0004}, H2={reqid,0x12,0x04}, 0xDEADBEEF with
//     tx_last; tx_error=0.
//  2. UR, len=5 -> 3 DW with H0 fmt=00 and length=0, H1[15:13]=001, tx_error=1 on all DW,
//     tx_last on H2; dat_ready never asserts.
//  3. SC, len=8; tx_ready toggles 1010..., dat_valid held low for 3 cycles mid-payload
//     -> 8 data DW in order; no drop or duplicate; tx_* stable while stalled.
//  4. Split enabled, MAX_PAYLOAD=16, addr=0x20, len=40, bytes=160
//     -> chunks of 8/16/16 DW; byte_count=160/128/64; lower_addr=0x20/0x40/0x00.
//  5. rst_n asserted during DATA of a len=16 TLP -> all outputs 0 asynchronously; next request
//     after release produces a fresh H0.
//  6. Two queued requests -> second H0 follows first tx_last after exactly one idle cycle.

Source files
------------

// File: rtl/dlsc_pcie_s6_cpl_gen_pkg.sv
// rtl/dlsc_pcie_s6_cpl_gen_pkg.sv - completion TLP codes, header field positions and FSM states
//
// Purpose: constants shared by the completion generator and the TX path.
//   CPL_*        completion status codes carried in H1[15:13]
//   FMT_*/TYPE_* H0 format/type for Cpl and CplD
//   H0_*_LSB     H0 bit-field positions
//   cpl_state_t  completion generator FSM states
//   cpl_h0()     assembles a completion H0 DW

package dlsc_pcie_s6_cpl_gen_pkg;

  localparam logic [2:0] CPL_SC   = 3'b000;
  localparam logic [2:0] CPL_UR   = 3'b001;
  localparam logic [2:0] CPL_CA   = 3'b100;

  localparam logic [1:0] FMT_CPL  = 2'b00;
  localparam logic [1:0] FMT_CPLD = 2'b10;
  localparam logic [4:0] TYPE_CPL = 5'b01010;

  localparam int H0_FMT_LSB  = 29;
  localparam int H0_TYPE_LSB = 24;
  localparam int H0_TC_LSB   = 20;
  localparam int H0_ATTR_LSB = 12;
  localparam int H1_STAT_LSB = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H0,
    ST_H1,
    ST_H2,
    ST_DATA
  } cpl_state_t;

  // TD, EP and reserved bits are always zero for generated completions.
  function automatic logic [31:0] cpl_h0(
    input logic       has_data,
    input logic [2:0] tc,
    input logic [1:0] attr,
    input logic [9:0] len
  );
    logic [31:0] h;
    h = '0;
    h[H0_FMT_LSB  +: 2] = has_data ? FMT_CPLD : FMT_CPL;
    h[H0_TYPE_LSB +: 5] = TYPE_CPL;
    h[H0_TC_LSB   +: 3] = tc;
    h[H0_ATTR_LSB +: 2] = attr;
    h[9:0]              = len;
    return h;
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_cpl_gen_if.sv
// rtl/dlsc_pcie_s6_cpl_gen_if.sv - request, read-data and TLP stream bundle of the completion generator
//
// Purpose: groups the three handshaked paths of the completion generator.
//   req_*  completion request (valid/ready) with header fields
//   dat_*  read-data stream, one DW per beat
//   tx_*   outgoing TLP stream towards the TX mux
// Modports: slave = completion generator, master = its environment.

interface dlsc_pcie_s6_cpl_gen_if;
  import dlsc_pcie_s6_cpl_gen_pkg::*;

  logic        req_ready;
  logic        req_valid;
  logic [2:0]  req_status;
  logic [15:0] req_reqid;
  logic [7:0]  req_tag;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic [6:0]  req_addr;
  logic [11:0] req_bytes;
  logic [9:0]  req_len;

  logic        dat_ready;
  logic        dat_valid;
  logic [31:0] dat_data;

  logic        tx_ready;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_error;
  logic [31:0] tx_data;

  modport slave (
    output req_ready,
    input  req_valid, req_status, req_reqid, req_tag, req_tc, req_attr,
           req_addr, req_bytes, req_len,
    output dat_ready,
    input  dat_valid, dat_data,
    input  tx_ready,
    output tx_valid, tx_last, tx_error, tx_data
  );

  modport master (
    input  req_ready,
    output req_valid, req_status, req_reqid, req_tag, req_tc, req_attr,
           req_addr, req_bytes, req_len,
    input  dat_ready,
    output dat_valid, dat_data,
    output tx_ready,
    input  tx_valid, tx_last, tx_error, tx_data
  );

endinterface

// File: rtl/dlsc_pcie_s6_cpl_gen.sv
// rtl/dlsc_pcie_s6_cpl_gen.sv - completion TLP generator for the inbound path
//
// Purpose: turns completion requests plus a read-data stream into 3DW Cpl/CplD TLPs on a
// 32-bit valid/ready stream. Unsuccessful completions are flagged with tx_error.
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   cpl_id  completer ID {bus,dev,func}, quasi-static
//   bus     slave modport: req_* (request in), dat_* (read data in), tx_* (TLP out)
// Parameters:
//   MAX_PAYLOAD  max CplD chunk in DW (power of 2, 1..32), used only when splitting
// Build option:
//   DLSC_PCIE_CPL_SPLIT_EN  split CplD into MAX_PAYLOAD-aligned chunks

module dlsc_pcie_s6_cpl_gen
  import dlsc_pcie_s6_cpl_gen_pkg::*;
#(
  parameter int MAX_PAYLOAD = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpl_id,
  dlsc_pcie_s6_cpl_gen_if.slave bus
);

`ifdef DLSC_PCIE_CPL_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam logic [10:0] MP = 11'(MAX_PAYLOAD);

  cpl_state_t  st;
  logic        req_ready_r;
  logic [2:0]  r_status;
  logic [15:0] r_reqid;
  logic [7:0]  r_tag;
  logic [2:0]  r_tc;
  logic [1:0]  r_attr;
  logic [6:0]  r_addr;    // running lower address of the current chunk
  logic [12:0] r_bytes;   // remaining byte count (4096 representable)
  logic [10:0] r_len;     // DW still to send, including current chunk
  logic [10:0] r_chunk;   // DW in current chunk
  logic [10:0] r_cnt;     // DW left in current chunk while in DATA

  logic        tx_valid_r;
  logic        tx_last_r;
  logic        tx_error_r;
  logic [31:0] tx_data_r;

  logic        ld;
  logic        is_sc;
  logic        dw_avail;
  logic        dw_last;
  logic        adv;
  logic [31:0] dw;

  logic [10:0] in_len;
  logic [12:0] in_bytes;
  logic [10:0] in_space;
  logic [10:0] in_chunk;
  logic [10:0] len_left;
  logic [10:0] nxt_chunk;
  logic [12:0] consumed;
  logic        more;

  // Output register may take a new DW whenever it is empty or being drained.
  assign ld    = bus.tx_ready || !tx_valid_r;
  assign is_sc = (r_status == CPL_SC);
  assign adv   = ld && dw_avail;

  assign bus.req_ready = req_ready_r;
  assign bus.dat_ready = (st == ST_DATA) && ld;
  assign bus.tx_valid  = tx_valid_r;
  assign bus.tx_last   = tx_last_r;
  assign bus.tx_error  = tx_error_r;
  assign bus.tx_data   = tx_data_r;

  // Chunk sizing. The first chunk stops at the next MAX_PAYLOAD*4 byte boundary so every
  // later chunk is naturally aligned; later chunks are simply MAX_PAYLOAD or the remainder.
  always_comb begin
    in_len    = (bus.req_len == 10'd0) ? 11'd1024 : {1'b0, bus.req_len};
    in_bytes  = (bus.req_bytes == 12'd0) ? 13'd4096 : {1'b0, bus.req_bytes};
    in_space  = MP - ({6'd0, bus.req_addr[6:2]} & (MP - 11'd1));
    in_chunk  = (SPLIT && (in_space < in_len)) ? in_space : in_len;
    len_left  = r_len - r_chunk;
    nxt_chunk = (SPLIT && (len_left > MP)) ? MP : len_left;
    more      = SPLIT && (len_left != 11'd0);
    // Only the first chunk can start unaligned; later r_addr[1:0] is always zero.
    consumed  = {r_chunk, 2'b00} - {11'd0, r_addr[1:0]};
  end

  // DW offered to the output register in each state.
  always_comb begin
    dw       = '0;
    dw_avail = 1'b0;
    dw_last  = 1'b0;
    case (st)
      ST_H0: begin
        dw_avail = 1'b1;
        dw       = cpl_h0(is_sc, r_tc, r_attr, is_sc ? r_chunk[9:0] : 10'd0);
      end
      ST_H1: begin
        dw_avail = 1'b1;
        dw       = {cpl_id, r_status, 1'b0, r_bytes[11:0]};
      end
      ST_H2: begin
        dw_avail = 1'b1;
        dw       = {r_reqid, r_tag, 1'b0, r_addr};
        dw_last  = !is_sc;
      end
      ST_DATA: begin
        dw_avail = bus.dat_valid;
        dw       = bus.dat_data;
        dw_last  = (r_cnt == 11'd1);
      end
      default: begin
        dw_avail = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_IDLE;
      req_ready_r <= 1'b0;
      r_status    <= '0;
      r_reqid     <= '0;
      r_tag       <= '0;
      r_tc        <= '0;
      r_attr      <= '0;
      r_addr      <= '0;
      r_bytes     <= '0;
      r_len       <= '0;
      r_chunk     <= '0;
      r_cnt       <= '0;
      tx_valid_r  <= 1'b0;
      tx_last_r   <= 1'b0;
      tx_error_r  <= 1'b0;
      tx_data_r   <= '0;
    end else begin
      if (ld) begin
        if (dw_avail) begin
          tx_valid_r <= 1'b1;
          tx_data_r  <= dw;
          tx_last_r  <= dw_last;
          tx_error_r <= !is_sc;
        end else begin
          tx_valid_r <= 1'b0;
          tx_last_r  <= 1'b0;
          tx_error_r <= 1'b0;
        end
      end

      case (st)
        ST_IDLE: begin
          // req_ready rises on the cycle after reset release and on every IDLE entry.
          if (req_ready_r && bus.req_valid) begin
            req_ready_r <= 1'b0;
            r_status    <= bus.req_status;
            r_reqid     <= bus.req_reqid;
            r_tag       <= bus.req_tag;
            r_tc        <= bus.req_tc;
            r_attr      <= bus.req_attr;
            r_addr      <= bus.req_addr;
            r_bytes     <= in_bytes;
            r_len       <= in_len;
            r_chunk     <= in_chunk;
            st          <= ST_H0;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_H0: begin
          if (adv) st <= ST_H1;
        end
        ST_H1: begin
          if (adv) st <= ST_H2;
        end
        ST_H2: begin
          if (adv) begin
            if (is_sc) begin
              r_cnt <= r_chunk;
              st    <= ST_DATA;
            end else begin
              req_ready_r <= 1'b1;
              st          <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (adv) begin
            r_cnt <= r_cnt - 11'd1;
            if (r_cnt == 11'd1) begin
              if (more) begin
                // Next chunk: headers re-emitted straight away, no IDLE visit.
                r_len   <= len_left;
                r_chunk <= nxt_chunk;
                r_bytes <= r_bytes - consumed;
                r_addr  <= r_addr + consumed[6:0];
                st      <= ST_H0;
              end else begin
                req_ready_r <= 1'b1;
                st          <= ST_IDLE;
              end
            end
          end
        end
        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
